shift_exec_stage: RTL and testbench

Two-stage pipelined shift/rotate execution unit for the cog ALU. It sits between operand fetch and flag/register writeback. It computes ROR, ROL, SHR, SHL, RCR, RCL, SAR and REV on 32-bit operands, along with Z and C. It uses a valid/ready handshake, forwards carry between back-to-back carry-consuming ops, and supports a pipeline flush.

---
 rtl/shift_exec_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift/rotate unit for the cog ALU: ROR/ROL/SHR/SHL/RCR/RCL/SAR/REV
// with Z/C flags, valid/ready handshake, carry forwarding between in-flight ops and flush.
module shift_exec_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_d,
  input  logic [4:0]  in_s,
  input  logic        in_c,
  input  logic        in_wz,
  input  logic        in_wc,
  input  logic        in_wr,
  input  logic [8:0]  in_dst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic        out_z,
  output logic        out_c,
  output logic        out_wz,
  output logic        out_wc,
  output logic        out_wr,
  output logic [8:0]  out_dst,
  output logic        busy
);

  typedef enum logic [2:0] {
    OP_ROR = 3'd0,
    OP_ROL = 3'd1,
    OP_SHR = 3'd2,
    OP_SHL = 3'd3,
    OP_RCR = 3'd4,
    OP_RCL = 3'd5,
    OP_SAR = 3'd6,
    OP_REV = 3'd7
  } op_e;

  function automatic logic [31:0] bit_rev(input logic [31:0] d);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      r[i] = d[31 - i];
    end
    return r;
  endfunction

  // Returns {carry, result}. Rotates use a doubled operand so any n in 0..31 is one shift.
  function automatic logic [32:0] shift_calc(input logic [2:0] op, input logic [31:0] d,
                                             input logic [4:0] n, input logic c);
    logic [63:0] dd;
    logic [32:0] v;
    logic [65:0] ww;
    logic [31:0] q;
    logic        co;
    dd = {d, d};
    v  = 33'd0;
    ww = 66'd0;
    q  = d;
    co = d[0];
    case (op)
      OP_ROR: begin
        dd = dd >> n;
        q  = dd[31:0];
        co = d[0];
      end
      OP_ROL: begin
        dd = dd << n;
        q  = dd[63:32];
        co = d[31];
      end
      OP_SHR: begin
        q  = d >> n;
        co = d[0];
      end
      OP_SHL: begin
        q  = d << n;
        co = d[31];
      end
      OP_RCR: begin
        v  = {d, c};
        ww = {v, v} >> n;
        q  = ww[32:1];
        co = ww[0];
      end
      OP_RCL: begin
        v  = {c, d};
        ww = {v, v} << n;
        q  = ww[64:33];
        co = ww[65];
      end
      OP_SAR: begin
        q  = $signed(d) >>> n;
        co = d[0];
      end
      OP_REV: begin
        q  = bit_rev(d) >> n;
        co = d[0];
      end
      default: begin
        q  = d;
        co = d[0];
      end
    endcase
    return {co, q};
  endfunction

  logic        s1_valid_r;
  logic [2:0]  s1_op_r;
  logic [31:0] s1_d_r;
  logic [4:0]  s1_n_r;
  logic        s1_c_r;
  logic        s1_wz_r;
  logic        s1_wc_r;
  logic        s1_wr_r;
  logic [8:0]  s1_dst_r;

  logic        s2_valid_r;
  logic [31:0] s2_q_r;
  logic        s2_z_r;
  logic        s2_c_r;
  logic        s2_wz_r;
  logic        s2_wc_r;
  logic        s2_wr_r;
  logic [8:0]  s2_dst_r;

  logic        pop_s;
  logic        s2_free_s;
  logic        s1_adv_s;
  logic        accept_s;
  logic [32:0] s1_res_s;
  logic        c1_s;

  assign out_valid = s2_valid_r & ~flush;
  assign pop_s     = out_valid & out_ready;
  assign s2_free_s = ~s2_valid_r | pop_s;
  assign s1_adv_s  = s1_valid_r & s2_free_s;
  assign in_ready  = (~s1_valid_r | s2_free_s) & ~flush;
  assign accept_s  = in_valid & in_ready;
  assign busy      = s1_valid_r | s2_valid_r;
  assign s1_res_s  = shift_calc(s1_op_r, s1_d_r, s1_n_r, s1_c_r);

  // Carry for the incoming op: youngest in-flight op that writes C, else the architectural flag.
  always_comb begin
    c1_s = in_c;
    if (s1_valid_r && s1_wc_r) begin
      c1_s = s1_res_s[32];
    end else if (s2_valid_r && s2_wc_r) begin
      c1_s = s2_c_r;
    end else begin
      c1_s = in_c;
    end
  end

  // Stage 1 operand register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 3'd0;
      s1_d_r     <= 32'd0;
      s1_n_r     <= 5'd0;
      s1_c_r     <= 1'b0;
      s1_wz_r    <= 1'b0;
      s1_wc_r    <= 1'b0;
      s1_wr_r    <= 1'b0;
      s1_dst_r   <= 9'd0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= in_op;
      s1_d_r     <= in_d;
      s1_n_r     <= in_s;
      s1_c_r     <= c1_s;
      s1_wz_r    <= in_wz;
      s1_wc_r    <= in_wc;
      s1_wr_r    <= in_wr;
      s1_dst_r   <= in_dst;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2 result register; drives the output bundle directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_q_r     <= 32'd0;
      s2_z_r     <= 1'b0;
      s2_c_r     <= 1'b0;
      s2_wz_r    <= 1'b0;
      s2_wc_r    <= 1'b0;
      s2_wr_r    <= 1'b0;
      s2_dst_r   <= 9'd0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_q_r     <= s1_res_s[31:0];
      s2_z_r     <= (s1_res_s[31:0] == 32'd0);
      s2_c_r     <= s1_res_s[32];
      s2_wz_r    <= s1_wz_r;
      s2_wc_r    <= s1_wc_r;
      s2_wr_r    <= s1_wr_r;
      s2_dst_r   <= s1_dst_r;
    end else if (pop_s) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign out_q   = s2_q_r;
  assign out_z   = s2_z_r;
  assign out_c   = s2_c_r;
  assign out_wz  = s2_wz_r;
  assign out_wc  = s2_wc_r;
  assign out_wr  = s2_wr_r;
  assign out_dst = s2_dst_r;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: vector table, hand-written corner sequences,
// and a randomized stream against a queue-based reference model.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_d;
  logic [4:0]  in_s;
  logic        in_c, in_wz, in_wc, in_wr;
  logic [8:0]  in_dst;
  logic        out_valid, out_ready;
  logic [31:0] out_q;
  logic        out_z, out_c, out_wz, out_wc, out_wr;
  logic [8:0]  out_dst;
  logic        busy;

  always #5 clk = ~clk;

  shift_exec_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_d(in_d), .in_s(in_s), .in_c(in_c), .in_wz(in_wz), .in_wc(in_wc),
    .in_wr(in_wr), .in_dst(in_dst), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_z(out_z), .out_c(out_c), .out_wz(out_wz), .out_wc(out_wc),
    .out_wr(out_wr), .out_dst(out_dst), .busy(busy)
  );

  typedef struct {
    logic [31:0] q;
    logic        z, c, wz, wc, wr;
    logic [8:0]  dst;
    int          stamp;
  } exp_t;

  typedef struct {
    logic [31:0] q;
    logic        z, c;
  } act_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    logic        c;
    logic [31:0] q;
    logic        z;
    logic        co;
  } vec_t;

  exp_t mq[$];
  act_t log_q[$];
  vec_t vt[12];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  logic last_acc;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference arithmetic written bit-by-bit from the op definitions; returns {C, q}.
  function automatic logic [32:0] ref_calc(input logic [2:0] op, input logic [31:0] d,
                                           input logic [4:0] n, input logic c);
    logic [31:0] q;
    logic [32:0] w;
    logic        co;
    q = d;
    co = d[0];
    w = 33'd0;
    case (op)
      3'd0: begin for (int i = 0; i < n; i++) q = {q[0], q[31:1]}; co = d[0]; end
      3'd1: begin for (int i = 0; i < n; i++) q = {q[30:0], q[31]}; co = d[31]; end
      3'd2: begin q = d >> n; co = d[0]; end
      3'd3: begin q = d << n; co = d[31]; end
      3'd4: begin
        w = {d, c};
        for (int i = 0; i < n; i++) w = {w[0], w[32:1]};
        q = w[32:1]; co = w[0];
      end
      3'd5: begin
        w = {c, d};
        for (int i = 0; i < n; i++) w = {w[31:0], w[32]};
        q = w[31:0]; co = w[32];
      end
      3'd6: begin for (int i = 0; i < n; i++) q = {q[31], q[31:1]}; co = d[0]; end
      default: begin
        for (int i = 0; i < 32; i++) q[i] = d[31 - i];
        q = q >> n; co = d[0];
      end
    endcase
    return {co, q};
  endfunction

  // One clock cycle: drive, check handshake/output against the model, update the model.
  task automatic step(input logic fl, input logic iv, input logic [2:0] op, input logic [31:0] d,
                      input logic [4:0] s, input logic c, input logic wz, input logic wc,
                      input logic wr, input logic [8:0] dst, input logic ordy);
    logic        exp_ov, exp_ir, pop, c1;
    logic [32:0] r;
    exp_t        e;
    act_t        a;
    @(negedge clk);
    flush = fl; in_valid = iv; in_op = op; in_d = d; in_s = s; in_c = c;
    in_wz = wz; in_wc = wc; in_wr = wr; in_dst = dst; out_ready = ordy;
    #1;
    exp_ov = !fl && mq.size() > 0 && edge_cnt > mq[0].stamp;
    exp_ir = !fl && (mq.size() < 2 || ordy);
    chk1("out_valid", out_valid, exp_ov);
    chk1("in_ready", in_ready, exp_ir);
    chk1("busy", busy, mq.size() > 0);
    pop = exp_ov && ordy;
    if (pop) begin
      chk32("out_q", out_q, mq[0].q);
      chk1("out_z", out_z, mq[0].z);
      chk1("out_c", out_c, mq[0].c);
      chk1("out_wz", out_wz, mq[0].wz);
      chk1("out_wc", out_wc, mq[0].wc);
      chk1("out_wr", out_wr, mq[0].wr);
      chk32("out_dst", {23'd0, out_dst}, {23'd0, mq[0].dst});
      a.q = out_q; a.z = out_z; a.c = out_c;
      log_q.push_back(a);
    end
    last_acc = iv && exp_ir;
    if (last_acc) begin
      c1 = c;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].wc) begin
          c1 = mq[i].c;
          break;
        end
      end
      r = ref_calc(op, d, s, c1);
      e.q = r[31:0]; e.z = (r[31:0] == 32'd0); e.c = r[32];
      e.wz = wz; e.wc = wc; e.wr = wr; e.dst = dst; e.stamp = edge_cnt + 1;
      mq.push_back(e);
    end
    if (pop) void'(mq.pop_front());
    if (fl) mq.delete();
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 3'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_out_q", out_q, 32'd0);
    chk1("rst_out_c", out_c, 1'b0);
    chk32("rst_out_dst", {23'd0, out_dst}, 32'd0);
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int n0, acc, cyc;
    logic [31:0] rd;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_d = 32'd0; in_s = 5'd0;
    in_c = 1'b0; in_wz = 1'b0; in_wc = 1'b0; in_wr = 1'b0; in_dst = 9'd0; out_ready = 1'b1;
    vt[0]  = '{3'd6, 32'h8000_0010, 5'd4,  1'b0, 32'hF800_0001, 1'b0, 1'b0};
    vt[1]  = '{3'd1, 32'h8000_0001, 5'd1,  1'b0, 32'h0000_0003, 1'b0, 1'b1};
    vt[2]  = '{3'd2, 32'h0000_0001, 5'd1,  1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vt[3]  = '{3'd4, 32'h0000_0001, 5'd1,  1'b1, 32'h8000_0000, 1'b0, 1'b1};
    vt[4]  = '{3'd5, 32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b0, 1'b1};
    vt[5]  = '{3'd0, 32'h0000_00F1, 5'd4,  1'b0, 32'h1000_000F, 1'b0, 1'b1};
    vt[6]  = '{3'd3, 32'h8000_0001, 5'd31, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[7]  = '{3'd7, 32'h0000_0001, 5'd0,  1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[8]  = '{3'd7, 32'h0000_0001, 5'd31, 1'b0, 32'h0000_0001, 1'b0, 1'b1};
    vt[9]  = '{3'd4, 32'h0000_0005, 5'd0,  1'b0, 32'h0000_0005, 1'b0, 1'b0};
    vt[10] = '{3'd5, 32'h8000_0000, 5'd1,  1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vt[11] = '{3'd6, 32'h7FFF_FFFF, 5'd31, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    #1;
    chk1("init_out_valid", out_valid, 1'b0);
    chk1("init_busy", busy, 1'b0);
    chk32("init_out_q", out_q, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("init_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      n0 = log_q.size();
      step(1'b0, 1'b1, vt[i].op, vt[i].d, vt[i].s, vt[i].c, 1'b1, 1'b0, 1'b1, 9'(i), 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk32("tbl_count", 32'(log_q.size()), 32'(n0 + 1));
      if (log_q.size() == n0 + 1) begin
        chk32("tbl_q", log_q[n0].q, vt[i].q);
        chk1("tbl_z", log_q[n0].z, vt[i].z);
        chk1("tbl_c", log_q[n0].c, vt[i].co);
      end
    end

    for (int rep = 0; rep < 2; rep++) begin
      n0 = log_q.size();
      step(1'b0, 1'b1, 3'd3, 32'h8000_0000, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd1, rep == 0);
      step(1'b0, 1'b1, 3'd5, 32'h0000_0000, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 9'd2, rep == 0);
      for (int k = 0; k < 3; k++) idle(rep == 0);
      for (int k = 0; k < 4; k++) idle(1'b1);
      chk32("fwd_count", 32'(log_q.size()), 32'(n0 + 2));
      if (log_q.size() == n0 + 2) begin
        chk32("fwd_first_q", log_q[n0].q, 32'd0);
        chk1("fwd_first_c", log_q[n0].c, 1'b1);
        chk32("fwd_second_q", log_q[n0 + 1].q, 32'h0000_0001);
        chk1("fwd_second_c", log_q[n0 + 1].c, 1'b0);
      end
    end

    step(1'b0, 1'b1, 3'd0, 32'h0000_0001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd3, 1'b0);
    step(1'b0, 1'b1, 3'd3, 32'h0000_0000, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd4, 1'b0);
    n0 = log_q.size();
    step(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 9'd5, 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);
    chk32("flush_no_output", 32'(log_q.size()), 32'(n0));
    step(1'b0, 1'b1, 3'd4, 32'h0000_0001, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd6, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk32("flush_rcr_count", 32'(log_q.size()), 32'(n0 + 1));
    if (log_q.size() == n0 + 1) begin
      chk32("flush_rcr_q", log_q[n0].q, 32'h8000_0000);
      chk1("flush_rcr_c", log_q[n0].c, 1'b1);
    end

    step(1'b0, 1'b1, 3'd0, 32'h1234_5678, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 9'd7, 1'b0);
    step(1'b0, 1'b1, 3'd1, 32'h1234_5678, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 9'd8, 1'b0);
    n0 = log_q.size();
    do_reset();
    for (int k = 0; k < 3; k++) idle(1'b1);
    chk32("reset_discard", 32'(log_q.size()), 32'(n0));

    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      case ($urandom_range(0, 3))
        0: rd = 32'd0;
        1: rd = 32'h8000_0000;
        default: rd = $urandom;
      endcase
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rd,
           5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           9'($urandom), $urandom_range(0, 3) != 0);
      if (last_acc) acc++;
      cyc++;
    end
    chk1("rand_budget", acc >= 1000, 1'b1);
    for (int k = 0; k < 4; k++) idle(1'b1);
    chk32("rand_drain", 32'(mq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
